// File: rtl/series_controller_pkg.sv
// Shared constants and state encoding for the series evaluation controller.
package series_controller_pkg;

    localparam int unsigned ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/term_counter.sv
// Term index counter: synchronous clear, increment enable, compare against the last index.
module term_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_nxt_c,
    output logic         term_o
);

    logic [W-1:0] cnt_q;

    // Clear wins over increment; the controller never asks for both.
    always_comb begin
        cnt_nxt_c = cnt_q;
        if (clr_i) begin
            cnt_nxt_c = '0;
        end else if (inc_i) begin
            cnt_nxt_c = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt_c;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == last_i);

endmodule

// File: rtl/series_controller.sv
// Sequences one power-series evaluation: init, then alternating multiply/accumulate
// strobes over coefficient addresses 0..n_last, then a single done pulse.
module series_controller
    import series_controller_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_last,
    output logic [ADDR_W-1:0] lut_addr,
    output logic              init_en,
    output logic              term_en,
    output logic              acc_en,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] n_last_q, n_last_d;
    logic              cnt_clr, cnt_inc, cnt_term;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    logic [ADDR_W-1:0] lut_addr_d;
    logic              init_en_d, term_en_d, acc_en_d, busy_d, done_d;

    term_counter #(
        .W (ADDR_W)
    ) u_term_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .last_i    (n_last_q),
        .cnt_o     (cnt),
        .cnt_nxt_c (cnt_nxt),
        .term_o    (cnt_term)
    );

    // Next state, then Moore outputs decoded from the next state so they can be registered.
    always_comb begin
        state_d    = state_q;
        n_last_d   = n_last_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        lut_addr_d = '0;
        init_en_d  = 1'b0;
        term_en_d  = 1'b0;
        acc_en_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_INIT;
                    n_last_d = n_last;
                    cnt_clr  = 1'b1;
                end
            end
            ST_INIT: state_d = ST_MUL;
            ST_MUL:  state_d = ST_ACC;
            ST_ACC: begin
                if (cnt_term) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_INIT: init_en_d = 1'b1;
            ST_MUL: begin
                term_en_d  = 1'b1;
                lut_addr_d = cnt_nxt;
            end
            ST_ACC: begin
                acc_en_d   = 1'b1;
                lut_addr_d = cnt_nxt;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_last_q <= '0;
            lut_addr <= '0;
            init_en  <= 1'b0;
            term_en  <= 1'b0;
            acc_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_last_q <= n_last_d;
            lut_addr <= lut_addr_d;
            init_en  <= init_en_d;
            term_en  <= term_en_d;
            acc_en   <= acc_en_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: doc/series_controller.md
SERIES_CONTROLLER -- requirements
Module: series_controller

Interface
REQ-001: The block SHALL have parameter ADDR_W, default 3, which is the width of the coefficient-table address (table depth 2**ADDR_W = 8).
REQ-002: The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003: The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004: The block SHALL have port start, input, 1 bit: request to begin one series evaluation; sampled only in IDLE.
REQ-005: The block SHALL have port n_last, input, ADDR_W bits: index of the last coefficient to use (terms = n_last+1, range 1..8); latched when start is accepted.
REQ-006: The block SHALL have port lut_addr, output, ADDR_W bits: coefficient-table address.
REQ-007: The block SHALL have port init_en, output, 1 bit: datapath loads x into its x register, 1 into its term register and 0 into its accumulator.
REQ-008: The block SHALL have port term_en, output, 1 bit: datapath updates term <= term * coef[lut_addr] (and * x).
REQ-009: The block SHALL have port acc_en, output, 1 bit: datapath updates acc <= acc + term.
REQ-010: The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011: The block SHALL have port done, output, 1 bit: single-cycle pulse indicating that the result is valid.

Function
REQ-012: The FSM SHALL have states IDLE, INIT, MUL, ACC and DONE, with Moore outputs only.
REQ-013: IDLE SHALL move to INIT when start=1; otherwise it SHALL stay in IDLE. On the transition it SHALL latch n_last and clear the term counter cnt to 0.
REQ-014: INIT SHALL assert init_en=1 for exactly 1 cycle and then go to MUL.
REQ-015: MUL SHALL drive lut_addr=cnt and term_en=1, then go to ACC.
REQ-016: ACC SHALL drive lut_addr=cnt and acc_en=1. If cnt==latched n_last it SHALL go to DONE; otherwise it SHALL set cnt<=cnt+1 and go to MUL.
REQ-017: DONE SHALL assert done=1 for 1 cycle and return to IDLE unconditionally.
REQ-018: In every state where a strobe is not specified, that strobe SHALL be 0. lut_addr SHALL be 0 in IDLE, INIT and DONE.
REQ-019: At most one of init_en, term_en and acc_en SHALL be high in any cycle.
REQ-020: Latency: if start is sampled high at edge k, then INIT occupies cycle k+1 and done is high in cycle k+2+2*(n_last+1). This is 4 cycles for n_last=0 and 18 cycles for n_last=7.
REQ-021: cnt SHALL be ADDR_W bits wide and SHALL never wrap, because termination at n_last ≤ 7 occurs before overflow.
REQ-022: start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023: A change of n_last input after acceptance SHALL NOT affect the running evaluation.
REQ-024: start held high continuously SHALL restart an evaluation in the cycle after DONE (IDLE samples it), so that DONE→IDLE→INIT runs back to back.

Reset
REQ-025: rst=1 at a clock edge SHALL force IDLE, cnt=0 and latched n_last=0 on that edge, regardless of state.
REQ-026: In the cycle after a reset edge, all outputs SHALL read lut_addr=0, init_en=0, term_en=0, acc_en=0, busy=0 and done=0.
REQ-027: Reset mid-operation SHALL abort without producing a done pulse. rst has priority over start in the same cycle.

Structure
REQ-028: A shared package SHALL hold the ADDR_W default and the state encoding constants (IDLE=0, INIT=1, MUL=2, ACC=3, DONE=4; 3-bit state).
REQ-029: The counter SHALL be a sub-module term_counter (ADDR_W-bit, synchronous clear, increment enable, terminal-compare output).
REQ-030: The coefficient table and arithmetic datapath SHALL remain outside this block and SHALL be connected through lut_addr and the strobes.

Verification
REQ-031: Reset, then idle 5 cycles with start=0 -> all outputs 0, busy=0, no strobes.
REQ-032: start pulse with n_last=7 -> init_en in cycle 1; term_en/acc_en alternate with lut_addr 0,0,1,1,…,7,7; done only in cycle 18; busy high in cycles 1–17 and in the DONE cycle.
REQ-033: start with n_last=0 -> exactly one term_en and one acc_en at addr 0; done in cycle 4.
REQ-034: start with n_last=3, then pulse start again and set n_last=7 during MUL -> both ignored; done in cycle 10 after 4 term pairs.
REQ-035: start with n_last=5, assert rst in the 2nd ACC cycle -> next cycle all outputs 0 and IDLE; no done; a new start afterwards runs a full evaluation normally.
REQ-036: start held high with n_last=1 for 20 cycles -> done pulses every 7 cycles (INIT, 4 strobe cycles, DONE, IDLE), with strobes never overlapping.
